// File: rtl/ethernet_reg_master.sv
// Command-stream to TCU config register master: burst reads/writes with address auto-increment.
// Optional misaligned-address rejection is enabled by defining ETH_REG_MASTER_ALIGN_CHECK_EN.
//
// state      | meaning
// IDLE       | waiting for a command
// WR_ACCEPT  | waiting for the next write beat
// WR_ISSUE   | write strobe for the latched beat
// WR_ACK     | write acknowledge presented
// RD_ISSUE   | read strobe
// RD_WAIT    | target drives read data, captured at end of cycle
// RD_RESP    | read data presented
// ERR_DRAIN  | discarding write beats of a rejected command
// ERR_RESP   | error response presented
module ethernet_reg_master #(
    parameter int TCU_REG_ADDR_SIZE = 32,
    parameter int TCU_REG_DATA_SIZE = 64,
    parameter int TCU_REG_BSEL_SIZE = 8,
    parameter int LEN_SIZE          = 4,
    parameter int ADDR_STRIDE       = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_write_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] cmd_addr_i,
    input  logic [LEN_SIZE-1:0]          cmd_len_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [TCU_REG_BSEL_SIZE-1:0] wr_wben_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] wr_data_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [TCU_REG_DATA_SIZE-1:0] rsp_data_o,
    output logic                         rsp_last_o,
    output logic                         rsp_err_o,
    output logic                         config_en_o,
    output logic [TCU_REG_BSEL_SIZE-1:0] config_wben_o,
    output logic [TCU_REG_ADDR_SIZE-1:0] config_addr_o,
    output logic [TCU_REG_DATA_SIZE-1:0] config_wdata_o,
    input  logic [TCU_REG_DATA_SIZE-1:0] config_rdata_i,
    output logic                         busy_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ACCEPT,
        S_WR_ISSUE,
        S_WR_ACK,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_RESP,
        S_ERR_DRAIN,
        S_ERR_RESP
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [TCU_REG_ADDR_SIZE-1:0] r_addr;
    logic [LEN_SIZE-1:0]          r_len;
    logic [LEN_SIZE-1:0]          r_beat;
    logic [TCU_REG_BSEL_SIZE-1:0] r_wben;
    logic [TCU_REG_DATA_SIZE-1:0] r_wdata;
    logic [TCU_REG_DATA_SIZE-1:0] r_rdata;
    logic                         w_last;
    logic                         w_cmd_fire;
    logic                         w_wr_fire;
    logic                         w_advance;
    logic                         w_misaligned;

    assign w_last     = (r_beat == r_len);
    assign w_cmd_fire = (r_state == S_IDLE) && cmd_valid_i;
    assign w_wr_fire  = (r_state == S_WR_ACCEPT) && wr_valid_i;

`ifdef ETH_REG_MASTER_ALIGN_CHECK_EN
    assign w_misaligned = (cmd_addr_i[2:0] != 3'b000);
    assign rsp_err_o    = (r_state == S_ERR_RESP);
`else
    assign w_misaligned = 1'b0;
    assign rsp_err_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (w_misaligned) begin
                        w_state_nxt = cmd_write_i ? S_ERR_DRAIN : S_ERR_RESP;
                    end else begin
                        w_state_nxt = cmd_write_i ? S_WR_ACCEPT : S_RD_ISSUE;
                    end
                end
            end
            S_WR_ACCEPT: begin
                if (wr_valid_i) begin
                    w_state_nxt = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (w_last) begin
                    w_state_nxt = S_WR_ACK;
                end else begin
                    w_state_nxt = S_WR_ACCEPT;
                    w_advance   = 1'b1;
                end
            end
            S_WR_ACK: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:  w_state_nxt = S_RD_RESP;
            S_RD_RESP: begin
                if (rsp_ready_i) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RD_ISSUE;
                        w_advance   = 1'b1;
                    end
                end
            end
            S_ERR_DRAIN: begin
                if (wr_valid_i) begin
                    if (w_last) begin
                        w_state_nxt = S_ERR_RESP;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_ERR_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_wben  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= cmd_addr_i;
                r_len  <= cmd_len_i;
                r_beat <= '0;
            end
            if (w_wr_fire) begin
                r_wben  <= wr_wben_i;
                r_wdata <= wr_data_i;
            end
            // address wraps modulo the address width
            if (w_advance) begin
                r_addr <= r_addr + TCU_REG_ADDR_SIZE'(ADDR_STRIDE);
                r_beat <= r_beat + LEN_SIZE'(1);
            end
            if (r_state == S_RD_WAIT) begin
                r_rdata <= config_rdata_i;
            end
        end
    end

    assign cmd_ready_o    = (r_state == S_IDLE);
    assign wr_ready_o     = (r_state == S_WR_ACCEPT) || (r_state == S_ERR_DRAIN);
    assign rsp_valid_o    = (r_state == S_WR_ACK) || (r_state == S_RD_RESP) || (r_state == S_ERR_RESP);
    assign rsp_last_o     = (r_state == S_WR_ACK) || (r_state == S_ERR_RESP) || ((r_state == S_RD_RESP) && w_last);
    assign rsp_data_o     = (r_state == S_RD_RESP) ? r_rdata : '0;
    // a zero byte-enable write would look like a read to the target, so it is suppressed
    assign config_en_o    = (r_state == S_RD_ISSUE) || ((r_state == S_WR_ISSUE) && (r_wben != '0));
    assign config_wben_o  = (r_state == S_WR_ISSUE) ? r_wben : '0;
    assign config_addr_o  = r_addr;
    assign config_wdata_o = r_wdata;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ethernet_reg_master.sv
// Bench for ethernet_reg_master: directed scenarios plus random command streams,
// checked against a transaction-level model of expected accesses and responses.
`timescale 1ns/1ps
module tb_ethernet_reg_master;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  wr_wben_i;
    logic [63:0] wr_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        rsp_last_o;
    logic        rsp_err_o;
    logic        config_en_o;
    logic [7:0]  config_wben_o;
    logic [31:0] config_addr_o;
    logic [63:0] config_wdata_o;
    logic [63:0] config_rdata_i;
    logic        busy_o;

    ethernet_reg_master dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_wben_i(wr_wben_i), .wr_data_i(wr_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .config_en_o(config_en_o), .config_wben_o(config_wben_o), .config_addr_o(config_addr_o),
        .config_wdata_o(config_wdata_o), .config_rdata_i(config_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [31:0] a; logic [7:0] wb; logic [63:0] d; } acc_t;
    typedef struct packed { logic [63:0] d; logic last; logic err; } rsp_t;

    int n_cmp = 0;
    int n_fail = 0;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    rsp_t seen_q[$];
    logic [63:0] tgt_mem [logic [31:0]];
    logic [63:0] ref_mem [logic [31:0]];
    logic [7:0]  beat_wben [16];
    logic [63:0] beat_data [16];
    int   rdy_pct = 100;
    bit   rdy_hold = 0;
    bit   cur_err = 0;
    int   en_count = 0;
    logic [31:0] last_en_addr;
    logic [7:0]  last_en_wben;
    logic [63:0] last_en_wdata;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endfunction

    function automatic logic [63:0] init_val(logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [7:0] wb, logic [63:0] d);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (wb[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] tgt_read(logic [31:0] a);
        return tgt_mem.exists(a) ? tgt_mem[a] : init_val(a);
    endfunction

    function automatic logic [63:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic void preload(logic [31:0] a, logic [63:0] d);
        tgt_mem[a] = d;
        ref_mem[a] = d;
    endfunction

    // Target register file: captures the strobe at negedge, acts on it at the next edge.
    logic        p_en;
    logic [7:0]  p_wb;
    logic [31:0] p_a;
    logic [63:0] p_d;
    always @(negedge clk_i) begin
        p_en = config_en_o; p_wb = config_wben_o; p_a = config_addr_o; p_d = config_wdata_o;
    end
    always @(posedge clk_i) begin
        if (p_en && p_wb != 8'h00) tgt_mem[p_a] = merge(tgt_read(p_a), p_wb, p_d);
        if (p_en && p_wb == 8'h00) config_rdata_i <= tgt_read(p_a);
        else config_rdata_i <= {$urandom, $urandom};
    end

    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            rsp_ready_i = rdy_hold ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    // Model: expected access list and response list for one command.
    task automatic model_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len);
        acc_t e;
        rsp_t r;
        bit mis = 0;
`ifdef ETH_REG_MASTER_ALIGN_CHECK_EN
        mis = (addr[2:0] != 3'b000);
`endif
        cur_err = mis;
        if (mis) begin
            r.d = 64'd0; r.last = 1'b1; r.err = 1'b1; rsp_q.push_back(r);
            return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            e.a = addr + 32'(i * 8);
            if (wr) begin
                if (beat_wben[i] != 8'h00) begin
                    e.wb = beat_wben[i]; e.d = beat_data[i]; acc_q.push_back(e);
                    ref_mem[e.a] = merge(ref_read(e.a), beat_wben[i], beat_data[i]);
                end
            end else begin
                e.wb = 8'h00; e.d = 64'd0; acc_q.push_back(e);
                r.d = ref_read(e.a); r.last = (i == int'(len)); r.err = 1'b0; rsp_q.push_back(r);
            end
        end
        if (wr) begin
            r.d = 64'd0; r.last = 1'b1; r.err = 1'b0; rsp_q.push_back(r);
        end
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len);
        int t = 0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
        forever begin
            @(negedge clk_i);
            if (cmd_ready_o) break;
            if (++t > 20) begin fail_now("cmd_accept"); break; end
        end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom); cmd_addr_i = $urandom; cmd_len_i = 4'($urandom);
    endtask

    task automatic send_beats(input logic [3:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            int t = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
            wr_valid_i = 1'b1; wr_wben_i = beat_wben[i]; wr_data_i = beat_data[i];
            forever begin
                @(negedge clk_i);
                if (wr_ready_o) break;
                if (++t > 50) begin fail_now("wr_accept"); break; end
            end
            @(posedge clk_i); #1;
            wr_valid_i = 1'b0; wr_wben_i = 8'($urandom); wr_data_i = {$urandom, $urandom};
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(rsp_q.size() == 0 && acc_q.size() == 0 && !busy_o)) begin
            @(negedge clk_i);
            if (++t > 3000) begin
                fail_now("cmd_done"); acc_q.delete(); rsp_q.delete(); break;
            end
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len);
        model_cmd(wr, addr, len);
        send_cmd(wr, addr, len);
        if (wr) send_beats(len);
        wait_done();
    endtask

    task automatic chk_reset_vals(string p);
        chk({p, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
        chk({p, "_wr_ready"}, 64'(wr_ready_o), 64'd0);
        chk({p, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({p, "_rsp_data"}, rsp_data_o, 64'd0);
        chk({p, "_rsp_last"}, 64'(rsp_last_o), 64'd0);
        chk({p, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        chk({p, "_en"}, 64'(config_en_o), 64'd0);
        chk({p, "_wben"}, 64'(config_wben_o), 64'd0);
        chk({p, "_addr"}, 64'(config_addr_o), 64'd0);
        chk({p, "_wdata"}, config_wdata_o, 64'd0);
        chk({p, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // Compare process: every cycle, away from the active edge.
    int   cyc = 0;
    int   en_cyc = 0;
    bit   rd_out = 0;
    bit   prev_valid = 0, prev_ready = 0, prev_last = 0, prev_wr_fire = 0;
    logic [63:0] prev_data;
    logic [7:0]  prev_wben;
    always @(negedge clk_i) begin
        acc_t e;
        rsp_t r, a;
        cyc++;
        if (!reset_n_i) begin
            prev_valid = 0; prev_ready = 0; prev_wr_fire = 0; rd_out = 0;
        end else begin
            chk("busy_vs_cmd_ready", 64'(busy_o), 64'(!cmd_ready_o));
            if (prev_wr_fire && !cur_err) chk("wr_accept_to_en", 64'(config_en_o), 64'(prev_wben != 8'h00));
            if (config_en_o) begin
                en_count++;
                last_en_addr = config_addr_o; last_en_wben = config_wben_o; last_en_wdata = config_wdata_o;
                if (acc_q.size() == 0) begin
                    chk("unexpected_en_addr", 64'(config_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = acc_q.pop_front();
                    chk("en_addr", 64'(config_addr_o), 64'(e.a));
                    chk("en_wben", 64'(config_wben_o), 64'(e.wb));
                    if (e.wb != 8'h00) chk("en_wdata", config_wdata_o, e.d);
                    else begin
                        chk("rd_one_outstanding", 64'(rd_out), 64'd0);
                        rd_out = 1; en_cyc = cyc;
                    end
                end
            end
            if (prev_valid && !prev_ready) begin
                chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
                chk("rsp_hold_data", rsp_data_o, prev_data);
                chk("rsp_hold_last", 64'(rsp_last_o), 64'(prev_last));
            end else if (rsp_valid_o && rd_out) begin
                chk("rd_en_to_valid", 64'(cyc - en_cyc), 64'd2);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                a.d = rsp_data_o; a.last = rsp_last_o; a.err = rsp_err_o;
                seen_q.push_back(a);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 64'(rsp_valid_o), 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_data", rsp_data_o, r.d);
                    chk("rsp_last", 64'(rsp_last_o), 64'(r.last));
                    chk("rsp_err", 64'(rsp_err_o), 64'(r.err));
                end
                rd_out = 0;
            end
            prev_valid = rsp_valid_o; prev_ready = rsp_ready_i;
            prev_data = rsp_data_o; prev_last = rsp_last_o;
            prev_wr_fire = wr_valid_i && wr_ready_o; prev_wben = wr_wben_i;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, k, t, rv;
        logic [31:0] addr;
        logic [3:0]  len;
        bit wr;
        reset_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        wr_valid_i = 1'b0; wr_wben_i = '0; wr_data_i = '0;
        @(negedge clk_i);
        chk_reset_vals("por");
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;

        // Single write
        rdy_pct = 100; seen_q.delete(); base = en_count;
        beat_wben[0] = 8'h0F; beat_data[0] = 64'hC0A8_2A19;
        run_cmd(1'b1, 32'h40, 4'd0);
        chk("sw_en_count", 64'(en_count - base), 64'd1);
        chk("sw_en_addr", 64'(last_en_addr), 64'h40);
        chk("sw_en_wben", 64'(last_en_wben), 64'h0F);
        chk("sw_en_wdata", last_en_wdata, 64'hC0A8_2A19);
        chk("sw_tgt_low", 64'(tgt_mem[32'h40][31:0]), 64'hC0A8_2A19);
        chk("sw_ack_count", 64'(seen_q.size()), 64'd1);
        chk("sw_busy_after", 64'(busy_o), 64'd0);

        // Read burst
        preload(32'h08, 64'h11); preload(32'h10, 64'h22); preload(32'h18, 64'h33);
        seen_q.delete(); base = en_count;
        run_cmd(1'b0, 32'h08, 4'd2);
        chk("rb_en_count", 64'(en_count - base), 64'd3);
        chk("rb_rsp_count", 64'(seen_q.size()), 64'd3);
        if (seen_q.size() == 3) begin
            chk("rb_d0", seen_q[0].d, 64'h11);
            chk("rb_d1", seen_q[1].d, 64'h22);
            chk("rb_d2", seen_q[2].d, 64'h33);
            chk("rb_last0", 64'(seen_q[0].last), 64'd0);
            chk("rb_last2", 64'(seen_q[2].last), 64'd1);
        end

        // Backpressure
        rdy_hold = 1;
        fork
            run_cmd(1'b0, 32'h20, 4'd1);
            begin
                t = 0;
                while (!rsp_valid_o && t < 50) begin @(negedge clk_i); t++; end
                if (!rsp_valid_o) fail_now("bp_first_valid");
                base = en_count;
                repeat (10) @(negedge clk_i);
                chk("bp_no_second_en", 64'(en_count - base), 64'd0);
                chk("bp_valid_held", 64'(rsp_valid_o), 64'd1);
                rdy_hold = 0;
            end
        join

        // Zero byte-enable beat and address wrap
        seen_q.delete(); base = en_count;
        beat_wben[0] = 8'h00; beat_data[0] = 64'h1234_5678_9ABC_DEF0;
        beat_wben[1] = 8'hFF; beat_data[1] = 64'hAA;
        run_cmd(1'b1, 32'hFFFF_FFF8, 4'd1);
        chk("zw_en_count", 64'(en_count - base), 64'd1);
        chk("zw_en_addr", 64'(last_en_addr), 64'h0);
        chk("zw_en_wdata", last_en_wdata, 64'hAA);
        chk("zw_tgt0", tgt_mem[32'h0], 64'hAA);
        chk("zw_no_write_top", 64'(tgt_mem.exists(32'hFFFF_FFF8)), 64'd0);
        chk("zw_ack_count", 64'(seen_q.size()), 64'd1);

        // Reset in RD_WAIT of beat 2 of 4
        rdy_pct = 100;
        model_cmd(1'b0, 32'h100, 4'd3);
        send_cmd(1'b0, 32'h100, 4'd3);
        k = 0; t = 0;
        while (k < 2 && t < 100) begin @(negedge clk_i); t++; if (config_en_o) k++; end
        if (k < 2) fail_now("rst_second_en");
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        acc_q.delete(); rsp_q.delete();
        @(negedge clk_i);
        chk_reset_vals("mid_rst");
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("rst_cmd_ready_after", 64'(cmd_ready_o), 64'd1);
        rv = 0;
        repeat (10) begin @(negedge clk_i); if (rsp_valid_o) rv++; end
        chk("rst_no_rsp", 64'(rv), 64'd0);

`ifdef ETH_REG_MASTER_ALIGN_CHECK_EN
        seen_q.delete(); base = en_count;
        run_cmd(1'b0, 32'h44, 4'd3);
        chk("al_no_en", 64'(en_count - base), 64'd0);
        chk("al_rsp_count", 64'(seen_q.size()), 64'd1);
        if (seen_q.size() == 1) begin
            chk("al_err", 64'(seen_q[0].err), 64'd1);
            chk("al_last", 64'(seen_q[0].last), 64'd1);
            chk("al_data", seen_q[0].d, 64'd0);
        end
`endif

        // Random command stream
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: addr = 32'hFFFF_FFC0 + 32'($urandom_range(0, 7) * 8);
                1: addr = $urandom;
                default: addr = 32'($urandom_range(0, 31)) << 3;
            endcase
            len = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                beat_wben[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                beat_data[i] = {$urandom, $urandom};
            end
            case ($urandom_range(0, 2))
                0: rdy_pct = 30;
                1: rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            run_cmd(wr, addr, len);
        end

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
